// File: rtl/dma_bus_scheduler.sv
// Arbitrates the CPU-owned system bus between the RX and TX DMA engines.
// Single registered FSM; every output is a flop updated alongside the state.
module dma_bus_scheduler #(
    parameter int MAX_HOLD = 16,
    parameter bit RR_EN    = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Ena,
    input  logic       Rx_Req,
    input  logic       Rx_End,
    output logic       Rx_Grant,
    input  logic       Tx_Req,
    input  logic       Tx_End,
    output logic       Tx_Grant,
    output logic       Bus_req,
    input  logic       Bus_grant,
    output logic [1:0] Owner,
    output logic       Timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_SAT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUS_WAIT = 3'd1,
        ST_GRANT_RX = 3'd2,
        ST_GRANT_TX = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    state_t          state_r;
    logic            sel_tx_r;
    logic            last_tx_r;
    logic [HW-1:0]   hold_cnt_r;

    logic            sel_next_tx_s;
    logic            sel_req_s;
    logic            sel_end_s;
    logic            normal_exit_s;
    logic            wd_hit_s;

    // Arbitration choice and exit conditions for the currently selected channel
    always_comb begin
        sel_next_tx_s = 1'b0;
        if (Rx_Req && Tx_Req) begin
            sel_next_tx_s = RR_EN ? ~last_tx_r : 1'b0;
        end else begin
            sel_next_tx_s = Tx_Req;
        end
        sel_req_s     = sel_tx_r ? Tx_Req : Rx_Req;
        sel_end_s     = sel_tx_r ? Tx_End : Rx_End;
        normal_exit_s = sel_end_s | ~sel_req_s | ~Bus_grant;
        wd_hit_s      = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r    <= ST_IDLE;
            sel_tx_r   <= 1'b0;
            last_tx_r  <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
            Rx_Grant   <= 1'b0;
            Tx_Grant   <= 1'b0;
            Bus_req    <= 1'b0;
            Owner      <= 2'b00;
            Timeout    <= 1'b0;
        end else begin
            Timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Ena && (Rx_Req || Tx_Req)) begin
                        state_r  <= ST_BUS_WAIT;
                        sel_tx_r <= sel_next_tx_s;
                        Bus_req  <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        Bus_req  <= 1'b0;
                    end
                end
                ST_BUS_WAIT: begin
                    // A withdrawn request wins over a grant arriving in the same cycle
                    if (!sel_req_s) begin
                        state_r <= ST_IDLE;
                        Bus_req <= 1'b0;
                    end else if (Bus_grant) begin
                        state_r    <= sel_tx_r ? ST_GRANT_TX : ST_GRANT_RX;
                        hold_cnt_r <= {HW{1'b0}};
                        Rx_Grant   <= ~sel_tx_r;
                        Tx_Grant   <= sel_tx_r;
                        Owner      <= sel_tx_r ? 2'b10 : 2'b01;
                    end else begin
                        state_r <= ST_BUS_WAIT;
                    end
                end
                ST_GRANT_RX, ST_GRANT_TX: begin
                    if (normal_exit_s || wd_hit_s) begin
                        state_r  <= ST_RELEASE;
                        Rx_Grant <= 1'b0;
                        Tx_Grant <= 1'b0;
                        Bus_req  <= 1'b0;
                        Owner    <= 2'b00;
                        Timeout  <= ~normal_exit_s;
                    end else begin
                        state_r <= state_r;
                        if (hold_cnt_r != HOLD_SAT) begin
                            hold_cnt_r <= hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                ST_RELEASE: begin
                    state_r   <= ST_IDLE;
                    last_tx_r <= sel_tx_r;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    Rx_Grant <= 1'b0;
                    Tx_Grant <= 1'b0;
                    Bus_req  <= 1'b0;
                    Owner    <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_scheduler.sv
// Randomised bench for dma_bus_scheduler: two configurations (16/RR and 4/fixed)
// run side by side against a transaction-level reference model.
module tb_dma_bus_scheduler;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst_n, Ena, Rx_Req, Rx_End, Tx_Req, Tx_End, Bus_grant;
    logic       rx_gnt_s  [2];
    logic       tx_gnt_s  [2];
    logic       bus_req_s [2];
    logic [1:0] owner_s   [2];
    logic       tmo_s     [2];

    dma_bus_scheduler #(.MAX_HOLD(16), .RR_EN(1'b1)) u_dut_rr (
        .Clk(Clk), .Rst_n(Rst_n), .Ena(Ena),
        .Rx_Req(Rx_Req), .Rx_End(Rx_End), .Rx_Grant(rx_gnt_s[0]),
        .Tx_Req(Tx_Req), .Tx_End(Tx_End), .Tx_Grant(tx_gnt_s[0]),
        .Bus_req(bus_req_s[0]), .Bus_grant(Bus_grant),
        .Owner(owner_s[0]), .Timeout(tmo_s[0])
    );

    dma_bus_scheduler #(.MAX_HOLD(4), .RR_EN(1'b0)) u_dut_fp (
        .Clk(Clk), .Rst_n(Rst_n), .Ena(Ena),
        .Rx_Req(Rx_Req), .Rx_End(Rx_End), .Rx_Grant(rx_gnt_s[1]),
        .Tx_Req(Tx_Req), .Tx_End(Tx_End), .Tx_Grant(tx_gnt_s[1]),
        .Bus_req(bus_req_s[1]), .Bus_grant(Bus_grant),
        .Owner(owner_s[1]), .Timeout(tmo_s[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 waiting for CPU, 2 owning, 3 handing back.
    // who/last: 1 = RX, 2 = TX. held = granted cycles completed so far.
    int m_phase [2];
    int m_who   [2];
    int m_last  [2];
    int m_held  [2];
    int m_to    [2];
    int MAXH    [2] = '{16, 4};
    int RRM     [2] = '{1, 0};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!Rst_n) begin
                m_phase[i] = 0; m_who[i] = 1; m_last[i] = 2; m_held[i] = 0; m_to[i] = 0;
            end else begin
                m_to[i] = 0;
                if (m_phase[i] == 0) begin
                    if (Ena && (Rx_Req || Tx_Req)) begin
                        if (Rx_Req && Tx_Req)
                            m_who[i] = (RRM[i] != 0) ? ((m_last[i] == 1) ? 2 : 1) : 1;
                        else
                            m_who[i] = Rx_Req ? 1 : 2;
                        m_phase[i] = 1;
                    end
                end else if (m_phase[i] == 1) begin
                    if (!((m_who[i] == 1) ? Rx_Req : Tx_Req)) m_phase[i] = 0;
                    else if (Bus_grant) begin m_phase[i] = 2; m_held[i] = 1; end
                end else if (m_phase[i] == 2) begin
                    bit norm, wd;
                    norm = (m_who[i] == 1) ? (Rx_End || !Rx_Req) : (Tx_End || !Tx_Req);
                    norm = norm || !Bus_grant;
                    wd   = (MAXH[i] != 0) && (m_held[i] == MAXH[i]);
                    if (norm || wd) begin
                        m_phase[i] = 3;
                        m_to[i]    = (wd && !norm) ? 1 : 0;
                    end else begin
                        m_held[i]++;
                    end
                end else begin
                    m_last[i]  = m_who[i];
                    m_phase[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            bit own;
            own = (m_phase[i] == 2);
            check_val($sformatf("bus_req[%0d]", i), bus_req_s[i], (m_phase[i] == 1 || own) ? 1 : 0);
            check_val($sformatf("rx_grant[%0d]", i), rx_gnt_s[i], (own && m_who[i] == 1) ? 1 : 0);
            check_val($sformatf("tx_grant[%0d]", i), tx_gnt_s[i], (own && m_who[i] == 2) ? 1 : 0);
            check_val($sformatf("owner[%0d]", i), owner_s[i], own ? m_who[i] : 0);
            check_val($sformatf("timeout[%0d]", i), tmo_s[i], m_to[i]);
            check_val($sformatf("grant_excl[%0d]", i), rx_gnt_s[i] & tx_gnt_s[i], 0);
            check_val($sformatf("grant_no_bg[%0d]", i), (rx_gnt_s[i] | tx_gnt_s[i]) & ~Bus_grant, 0);
        end
    endtask

    task automatic cycle(input logic rst_n, input logic ena, input logic rxr, input logic rxe,
                         input logic txr, input logic txe, input logic bg);
        @(negedge Clk);
        compare_all();
        Rst_n = rst_n; Ena = ena; Rx_Req = rxr; Rx_End = rxe;
        Tx_Req = txr; Tx_End = txe; Bus_grant = bg;
        model_step();
    endtask

    logic rq_rx, rq_tx, bg_v;

    initial begin
        Rst_n = 1'b0; Ena = 1'b0; Rx_Req = 1'b0; Rx_End = 1'b0;
        Tx_Req = 1'b0; Tx_End = 1'b0; Bus_grant = 1'b0;
        model_step();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // RX-only transfer: request c0, CPU grant from c2, end pulse c6
        for (int c = 0; c < 10; c++)
            cycle(1'b1, 1'b1, (c <= 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0,
                  1'b0, 1'b0, (c >= 2 && c <= 6) ? 1'b1 : 1'b0);

        // Both request after reset with the bus freely granted
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++)
            cycle(1'b1, 1'b1, 1'b1, (c % 7 == 5) ? 1'b1 : 1'b0, 1'b1, (c % 7 == 5) ? 1'b1 : 1'b0, 1'b1);

        // Ena low blocks new arbitration
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        rq_rx = 1'b0; rq_tx = 1'b0; bg_v = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                logic rst_v, ena_v, rxe, txe;
                rst_v = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                ena_v = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                if ($urandom_range(0, (seg == 1) ? 39 : 9) == 0) rq_rx = ~rq_rx;
                if ($urandom_range(0, (seg == 1) ? 39 : 9) == 0) rq_tx = ~rq_tx;
                if ($urandom_range(0, (seg == 2) ? 3 : 24) == 0) bg_v = ~bg_v;
                rxe = ($urandom_range(0, (seg == 1) ? 59 : 5) == 0) ? 1'b1 : 1'b0;
                txe = ($urandom_range(0, (seg == 1) ? 59 : 5) == 0) ? 1'b1 : 1'b0;
                if (seg == 3) begin
                    rq_rx = 1'b1; rq_tx = 1'b1; bg_v = 1'b1; ena_v = 1'b1;
                end
                cycle(rst_v, ena_v, rq_rx, rxe, rq_tx, txe, bg_v);
            end
        end

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        compare_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
